gate_bist_seq: RTL and testbench
================================

Name: gate_bist_seq

Overview:
- Hardware stimulus/response sequencer for small registered 2-input logic units (AND/OR/XOR cells with a, b, out, clk).
- It drives the unit's a/b inputs through every input combination, holding each combination for a fixed number of cycles.
- It samples the unit's output and compares it against the expected AND result, then reports pass/fail and a mismatch count.
- It is the synthesizable driver/checker end of the unit's a/b -> out interface and sits beside the DUT for on-chip self-test.

Parameters:
- NBITS, 1, width of each operand and of the DUT output.
- HOLD_CYCLES, 5, cycles each vector is held on a_out/b_out. Legal range: HOLD_CYCLES > LAT.
- LAT, 1, DUT input-to-output latency in clk cycles. Range 0..HOLD_CYCLES-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; sampled in IDLE and DONE only.
- dut_out  in  NBITS  output of the unit under test.
- a_out  out  NBITS  operand a driven to the DUT.
- b_out  out  NBITS  operand b driven to the DUT.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  done && (err_cnt == 0).
- err_cnt  out  2*NBITS+1  count of mismatching vectors; saturates at all-ones.
- vec_idx  out  2*NBITS  index of the vector currently applied.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset, asserted at any time: state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0, hold counter=0. Takes effect immediately, independent of clk.
- Vector mapping:
  - a_out = vec_idx[NBITS-1:0]; b_out = vec_idx[2*NBITS-1:NBITS].
  - For NBITS=1 the order is (a,b) = 00, 10, 01, 11.
  - LAST = 2^(2*NBITS)-1.
- All outputs are registered; a_out/b_out change only on clk edges.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Outputs at reset values.
  - start=1 -> RUN, with vec_idx=0, hold=0, err_cnt=0.
- RUN:
  - busy=1. The hold counter increments each cycle.
  - When hold==HOLD_CYCLES-1, on that edge:
    - compare dut_out with (a_out & b_out);
    - if they differ, err_cnt += 1, saturating at all-ones;
    - then, if vec_idx==LAST -> DONE; else vec_idx+1 and hold=0.
  - Each vector is therefore applied for exactly HOLD_CYCLES cycles. Because LAT < HOLD_CYCLES, the output sampled at the comparison point belongs to the current vector.
  - start is ignored in RUN; there is no abort other than rst.
- DONE:
  - done=1, pass combinational from err_cnt, a_out=b_out=0, vec_idx=0.
  - err_cnt is held until the next start.
  - start=1 -> RUN as from IDLE, with err_cnt cleared on the same edge.
- Timing: with start sampled at edge 0, DONE is entered at edge 2^(2*NBITS)*HOLD_CYCLES (edge 20 for the defaults). busy is high for exactly that many cycles.
- Simultaneous events: rst overrides start. start and the final-compare edge cannot coincide, since start is ignored in RUN.
- dut_out X/Z is treated as a mismatch by the bench model only; the RTL compares bitwise.

Decomposition:
- Package gate_bist_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - width helper functions VEC_W(NBITS)=2*NBITS and ERR_W(NBITS)=2*NBITS+1.
- One natural sub-module, gate_vec_seq: hold counter plus vector index counter with a wrap/last flag. The FSM, comparator and error counter stay in gate_bist_seq.

Test Plan:
- Defaults, golden registered AND model (LAT=1), start pulse at cycle 2:
  - a/b sequence 00,10,01,11, each held 5 cycles;
  - done rises 20 cycles after start; pass=1; err_cnt=0.
- DUT stuck-at-0 -> only vector 11 mismatches: err_cnt=1, pass=0.
- DUT implements OR -> vectors 10 and 01 mismatch: err_cnt=2, pass=0.
- Second start pulse at cycle 7 of RUN is ignored: vec_idx progression unchanged, done still at cycle 20. A start in DONE reruns, clearing err_cnt.
- rst asserted mid-cycle during vector 2 -> all outputs 0 immediately (before the next edge), state IDLE. A later start reruns cleanly from vec_idx=0.
- NBITS=2, HOLD_CYCLES=3, LAT=2, golden model:
  - 16 vectors, done 48 cycles after start, pass=1;
  - err_cnt width 5; with the DUT output inverted, err_cnt=16.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and width helpers for the gate BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int VEC_W(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int ERR_W(input int nbits);
        return 2 * nbits + 1;
    endfunction

endpackage

// File: rtl/gate_bist_seq_if.sv
// Stimulus/response bundle between the BIST sequencer and its environment.
interface gate_bist_seq_if #(
    parameter int NBITS = 1
);
    import gate_bist_pkg::*;

    logic                      start;
    logic [NBITS-1:0]          dut_out;
    logic [NBITS-1:0]          a_out;
    logic [NBITS-1:0]          b_out;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [ERR_W(NBITS)-1:0]   err_cnt;
    logic [VEC_W(NBITS)-1:0]   vec_idx;

    modport master (
        input  start, dut_out,
        output a_out, b_out, busy, done, pass, err_cnt, vec_idx
    );

    modport slave (
        output start, dut_out,
        input  a_out, b_out, busy, done, pass, err_cnt, vec_idx
    );

endinterface

// File: rtl/gate_vec_seq.sv
// Hold counter and vector index counter; flags the sample edge and the last vector.
module gate_vec_seq
    import gate_bist_pkg::*;
#(
    parameter int NBITS       = 1,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    output logic [VEC_W(NBITS)-1:0] vec_idx,
    output logic                    sample,
    output logic                    last
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [HW-1:0] hold;

    assign sample = en && (hold == HW'(HOLD_CYCLES - 1));
    assign last   = sample && (vec_idx == '1);

    // vec_idx wraps to zero naturally after LAST, leaving DONE at index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= '0;
            vec_idx <= '0;
        end else if (clear) begin
            hold    <= '0;
            vec_idx <= '0;
        end else if (sample) begin
            hold    <= '0;
            vec_idx <= vec_idx + 1'b1;
        end else if (en) begin
            hold    <= hold + 1'b1;
        end
    end

endmodule

// File: rtl/gate_bist_seq.sv
// BIST driver/checker: walks every a/b combination, compares the unit output
// against a & b at the end of each hold window and counts mismatches.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int NBITS       = 1,
    parameter int HOLD_CYCLES = 5,
    parameter int LAT         = 1
) (
    input  logic            clk,
    input  logic            rst,
    gate_bist_seq_if.master bus
);

    localparam int VW = VEC_W(NBITS);
    localparam int EW = ERR_W(NBITS);
    // An out-of-range latency can never be sampled correctly, so force failures
    localparam bit LAT_OK = (LAT >= 0) && (LAT < HOLD_CYCLES);

    state_t           state;
    logic [EW-1:0]    err_cnt;
    logic [VW-1:0]    vec_idx;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             en;
    logic             clear;
    logic             sample;
    logic             last;
    logic             mismatch;

    assign en       = (state == RUN);
    assign clear    = (state != RUN) && bus.start;
    assign a        = vec_idx[NBITS-1:0];
    assign b        = vec_idx[VW-1:NBITS];
    assign mismatch = (bus.dut_out != (a & b)) || !LAT_OK;

    gate_vec_seq #(
        .NBITS       (NBITS),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_vec (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .en      (en),
        .vec_idx (vec_idx),
        .sample  (sample),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        err_cnt <= '0;
                    end
                end
                RUN: begin
                    if (sample && mismatch && (err_cnt != '1))
                        err_cnt <= err_cnt + 1'b1;
                    if (last)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out   = a;
    assign bus.b_out   = b;
    assign bus.vec_idx = vec_idx;
    assign bus.err_cnt = err_cnt;
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.pass    = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_gate_bist_seq.sv
// Scoreboard bench for gate_bist_seq: stimulus queues expected per-cycle
// vectors and run results, a negedge monitor pops and compares them.
module tb_gate_bist_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gate_bist_seq_if #(.NBITS(1)) i0 ();
    gate_bist_seq_if #(.NBITS(2)) i1 ();

    gate_bist_seq #(.NBITS(1), .HOLD_CYCLES(5), .LAT(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (i0)
    );

    gate_bist_seq #(.NBITS(2), .HOLD_CYCLES(3), .LAT(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int sel         = 0;
    int mode0       = 0;
    int mode1       = 0;

    // Unit models: 0 AND, 1 stuck-at-0, 2 OR, 3 inverted AND
    function automatic logic [1:0] unit_f(input int mode, input logic [1:0] a, input logic [1:0] b);
        case (mode)
            0:       return a & b;
            1:       return 2'b00;
            2:       return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    logic [1:0] f0;
    logic [1:0] p1;
    assign f0 = unit_f(mode0, {1'b0, i0.a_out}, {1'b0, i0.b_out});

    always @(posedge clk) i0.dut_out <= f0[0];

    always @(posedge clk) begin
        p1         <= unit_f(mode1, i1.a_out, i1.b_out);
        i1.dut_out <= p1;
    end

    typedef struct {
        int a;
        int b;
        int idx;
    } cyc_t;

    typedef struct {
        int err;
        int ps;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic read_outs(output int a, output int b, output int idx, output int err,
                             output int ps, output int bs, output int dn);
        if (sel == 0) begin
            a = int'(i0.a_out); b = int'(i0.b_out); idx = int'(i0.vec_idx);
            err = int'(i0.err_cnt); ps = int'(i0.pass); bs = int'(i0.busy); dn = int'(i0.done);
        end else begin
            a = int'(i1.a_out); b = int'(i1.b_out); idx = int'(i1.vec_idx);
            err = int'(i1.err_cnt); ps = int'(i1.pass); bs = int'(i1.busy); dn = int'(i1.done);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) i0.start = v;
        else          i1.start = v;
    endtask

    // Monitor
    int   m_a, m_b, m_idx, m_err, m_ps, m_bs, m_dn;
    bit   prev_done = 1'b0;
    cyc_t m_c;
    res_t m_r;

    always @(negedge clk) begin
        read_outs(m_a, m_b, m_idx, m_err, m_ps, m_bs, m_dn);
        if (m_bs != 0) begin
            if (cyc_q.size() == 0) begin
                chk("busy_extra_cycle", m_bs, 0);
            end else begin
                m_c = cyc_q.pop_front();
                chk("a_out", m_a, m_c.a);
                chk("b_out", m_b, m_c.b);
                chk("vec_idx", m_idx, m_c.idx);
            end
        end
        if (m_dn != 0 && !prev_done) begin
            chk("done_early", cyc_q.size(), 0);
            if (res_q.size() == 0) begin
                chk("done_unexpected", m_dn, 0);
            end else begin
                m_r = res_q.pop_front();
                chk("err_cnt", m_err, m_r.err);
                chk("pass", m_ps, m_r.ps);
                chk("done_a_out", m_a, 0);
                chk("done_b_out", m_b, 0);
                chk("done_vec_idx", m_idx, 0);
            end
        end
        prev_done = (m_dn != 0);
    end

    task automatic start_run(input int nb, input int hold, input int err, input int ps);
        cyc_t c;
        res_t r;
        for (int k = 0; k < (1 << (2 * nb)); k++) begin
            for (int h = 0; h < hold; h++) begin
                c.a   = k & ((1 << nb) - 1);
                c.b   = k >> nb;
                c.idx = k;
                cyc_q.push_back(c);
            end
        end
        r.err = err;
        r.ps  = ps;
        res_q.push_back(r);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
    endtask

    task automatic wait_done(input int n0, input int budget, input int exp_lat);
        int n;
        int a, b, idx, err, ps, bs, dn;
        n = n0;
        do begin
            @(posedge clk);
            #1;
            n++;
            read_outs(a, b, idx, err, ps, bs, dn);
        end while (dn == 0 && n < budget);
        chk("done_latency", n, exp_lat);
        @(posedge clk);
        #1;
    endtask

    int a, b, idx, err, ps, bs, dn;

    initial begin
        i0.start = 1'b0;
        i1.start = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #2;
        read_outs(a, b, idx, err, ps, bs, dn);
        chk("rst_a_out", a, 0);
        chk("rst_b_out", b, 0);
        chk("rst_vec_idx", idx, 0);
        chk("rst_err_cnt", err, 0);
        chk("rst_pass", ps, 0);
        chk("rst_busy", bs, 0);
        chk("rst_done", dn, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Golden AND unit
        mode0 = 0;
        start_run(1, 5, 0, 1);
        wait_done(0, 40, 20);

        // Stuck-at-0: only vector 11 fails
        mode0 = 1;
        start_run(1, 5, 1, 0);
        wait_done(0, 40, 20);

        // OR unit: vectors 10 and 01 fail; extra start at cycle 7 is ignored
        mode0 = 2;
        start_run(1, 5, 2, 0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        wait_done(7, 40, 20);

        // Restart from DONE clears err_cnt
        mode0 = 0;
        start_run(1, 5, 0, 1);
        wait_done(0, 40, 20);

        // Reset mid-cycle during vector 2
        mode0 = 2;
        start_run(1, 5, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        read_outs(a, b, idx, err, ps, bs, dn);
        chk("pre_rst_vec_idx", idx, 2);
        chk("pre_rst_err_cnt", err, 1);
        #1 rst = 1'b1;
        #1;
        read_outs(a, b, idx, err, ps, bs, dn);
        chk("mid_rst_a_out", a, 0);
        chk("mid_rst_b_out", b, 0);
        chk("mid_rst_vec_idx", idx, 0);
        chk("mid_rst_err_cnt", err, 0);
        chk("mid_rst_busy", bs, 0);
        chk("mid_rst_done", dn, 0);
        chk("mid_rst_pass", ps, 0);
        cyc_q.delete();
        res_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        mode0 = 0;
        start_run(1, 5, 0, 1);
        wait_done(0, 40, 20);

        // NBITS=2, HOLD_CYCLES=3, LAT=2
        sel   = 1;
        mode1 = 0;
        start_run(2, 3, 0, 1);
        wait_done(0, 80, 48);

        mode1 = 3;
        start_run(2, 3, 16, 0);
        wait_done(0, 80, 48);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
